btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter cDB, default 500000, meaning consecutive stable cycles required to accept a new input level (10 ms at 50 MHz).
REQ-002 SHALL have parameter cREP, default 12500000, meaning auto-repeat period in cycles (used only with BTN_COND_REPEAT_EN).
REQ-003 SHALL have port iCLK_50, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port iRST_N, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port iBTN, input, 2 bits: raw asynchronous push buttons, 1 = pressed.
REQ-006 SHALL have port iSW, input, 4 bits: raw asynchronous slide switches.
REQ-007 SHALL have port oBTN_LVL, output, 2 bits: debounced button levels.
REQ-008 SHALL have port oBTN_PULSE, output, 2 bits: one-cycle press strobes, for the downstream counter's iBTN.
REQ-009 SHALL have port oSW, output, 4 bits: debounced switch levels, for the downstream counter's iSW.

Function
REQ-010 SHALL pass each raw input bit through a 2-flop synchronizer before any other logic.
REQ-011 SHALL keep, per channel, a stable-counter of width $clog2(cDB+1) that clears on any cycle where the synchronized input equals the current debounced level.
REQ-012 SHALL increment the counter on each cycle where the synchronized input differs from the debounced level.
REQ-013 SHALL toggle the debounced level, and clear the counter, on the edge where the counter would reach cDB; latency from a clean raw edge to the output change is therefore 2+cDB cycles.
REQ-014 SHALL discard any glitch shorter than cDB synchronized cycles, with no output change and the counter cleared.
REQ-015 SHALL implement a per-button FSM with states IDLE, PRESSED and REPEAT (REPEAT reachable only with the macro).
REQ-016 SHALL move IDLE->PRESSED on the debounced rising edge and assert oBTN_PULSE for exactly that one cycle.
REQ-017 SHALL return PRESSED/REPEAT->IDLE on the debounced falling edge, with no pulse.
REQ-018 SHALL handle the two buttons independently; simultaneous presses SHALL produce both strobes in the same cycle.
REQ-019 SHALL register all outputs, with no combinational path from input to output.

Reset
REQ-020 SHALL, while iRST_N=0, force synchronizers, counters, levels and FSMs to zero/IDLE, with oBTN_LVL=0, oBTN_PULSE=0 and oSW=0.
REQ-021 SHALL, on reset deassertion with a button held, debounce that button as a new press (pulse after 2+cDB cycles).
REQ-022 SHALL, on reset mid-count, discard the partial count.

Configuration
REQ-023 SHALL, with BTN_COND_REPEAT_EN defined, add a per-button repeat timer that moves PRESSED->REPEAT after cREP held cycles and then issues one oBTN_PULSE every cREP cycles while the button stays held; the timer resets on release.
REQ-024 SHALL, without BTN_COND_REPEAT_EN, omit the repeat timer and the REPEAT state, giving exactly one pulse per press.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, PRESSED, REPEAT) and default constants in package btn_cond_pkg.
REQ-026 SHALL implement synchronizer plus debounce counter plus level in sub-module db_chan (parameter cDB), instantiated six times (2 buttons, 4 switches).

Verification (bench uses cDB=2, cREP=8, iCLK_50 period 4 ns)
REQ-027 SHALL cover reset: iRST_N=0 with iBTN=2'b11, iSW=4'hF -> all outputs 0; after release -> oSW=4'hF and oBTN_PULSE=2'b11 for one cycle at cycle 4.
REQ-028 SHALL cover a clean press: iBTN[0] 0->1 held 20 cycles -> oBTN_LVL[0]=1 and a single oBTN_PULSE[0] 4 cycles after the edge; release -> oBTN_LVL[0]=0 4 cycles later, no pulse.
REQ-029 SHALL cover a glitch: iBTN[1]=1 for 1 cycle -> oBTN_LVL[1] and oBTN_PULSE[1] stay 0.
REQ-030 SHALL cover switch bounce: iSW[2] toggled 1/0/1 on successive cycles then held 1 -> exactly one 0->1 transition of oSW[2], counted from the last toggle.
REQ-031 SHALL cover repeat (macro on): iBTN[0] held 30 cycles -> pulses at cycles 4, 12, 20 and 28 after the edge; macro off -> pulse at cycle 4 only.
REQ-032 SHALL cover reset mid-count: iRST_N pulsed low during the first debounce cycle of a press -> no pulse until 2+cDB cycles after deassertion.

Source files
------------

// File: rtl/btn_cond_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_cond_pkg : shared FSM state type and defaults for btn_conditioner |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_e;

  localparam int unsigned C_DB_DEFAULT  = 500000;    // 10 ms at 50 MHz
  localparam int unsigned C_REP_DEFAULT = 12500000;  // 250 ms at 50 MHz
  localparam int unsigned C_NUM_BTN     = 2;
  localparam int unsigned C_NUM_SW      = 4;

endpackage
`default_nettype wire

// File: rtl/db_chan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | db_chan : 2-flop synchronizer, stable counter and debounced level    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module db_chan
  import btn_cond_pkg::*;
#(
  parameter int unsigned cDB = C_DB_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic lvl_o,
  output logic tog_o
);

  localparam int unsigned CW = $clog2(cDB + 1);

  logic [1:0]    sync_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tog;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any cycle that agrees with the current level restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    tog   = 1'b0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(cDB - 1)) begin
        tog   = 1'b1;
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign lvl_o = lvl_q;
  assign tog_o = tog;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_conditioner : debounces 2 buttons + 4 switches, press strobes    |
// | Optional auto-repeat enabled by defining BTN_COND_REPEAT_EN. Rev 1.0 |
// +--------------------------------------------------------------------+
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned cDB  = C_DB_DEFAULT,
  parameter int unsigned cREP = C_REP_DEFAULT
) (
  input  logic       iCLK_50,
  input  logic       iRST_N,
  input  logic [1:0] iBTN,
  input  logic [3:0] iSW,
  output logic [1:0] oBTN_LVL,
  output logic [1:0] oBTN_PULSE,
  output logic [3:0] oSW
);

  localparam int unsigned NCH = C_NUM_BTN + C_NUM_SW;

  logic [NCH-1:0]      raw_w, lvl_w, tog_w;
  logic [C_NUM_SW-1:0] sw_tog_unused;
  logic                unused_cfg;

  assign raw_w = {iSW, iBTN};

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    db_chan #(.cDB(cDB)) u_db (
      .clk_i  (iCLK_50),
      .rst_ni (iRST_N),
      .raw_i  (raw_w[c]),
      .lvl_o  (lvl_w[c]),
      .tog_o  (tog_w[c])
    );
  end

  assign oBTN_LVL = lvl_w[C_NUM_BTN-1:0];
  assign oSW      = lvl_w[NCH-1:C_NUM_BTN];

  // Switches need no edge strobe; cREP is only consumed by the repeat timer.
  assign sw_tog_unused = tog_w[NCH-1:C_NUM_BTN];
  assign unused_cfg    = ^{sw_tog_unused, cREP};

`ifdef BTN_COND_REPEAT_EN
  localparam int unsigned REP_W = (cREP > 1) ? $clog2(cREP) : 1;
`endif

  for (genvar b = 0; b < C_NUM_BTN; b++) begin : g_btn
    btn_state_e st_q, st_d;
    logic       pulse_q, pulse_d;
    logic       rise_w, fall_w;

    // Edge events come from the channel's next-level decision so the strobe
    // lands in the same cycle as the level change.
    assign rise_w = tog_w[b] & ~lvl_w[b];
    assign fall_w = tog_w[b] &  lvl_w[b];

`ifdef BTN_COND_REPEAT_EN
    logic [REP_W-1:0] rep_q, rep_d;

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) rep_q <= '0;
      else         rep_q <= rep_d;
    end
`endif

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
        st_q    <= IDLE;
        pulse_q <= 1'b0;
      end else begin
        st_q    <= st_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      st_d    = st_q;
      pulse_d = 1'b0;
`ifdef BTN_COND_REPEAT_EN
      rep_d   = rep_q;
`endif
      case (st_q)
        IDLE: begin
          if (rise_w) begin
            st_d    = PRESSED;
            pulse_d = 1'b1;
`ifdef BTN_COND_REPEAT_EN
            rep_d   = '0;
`endif
          end
        end
        PRESSED, REPEAT: begin
          if (fall_w) begin
            st_d  = IDLE;
`ifdef BTN_COND_REPEAT_EN
            rep_d = '0;
`endif
          end
`ifdef BTN_COND_REPEAT_EN
          else if (rep_q == REP_W'(cREP - 1)) begin
            st_d    = REPEAT;
            pulse_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
`endif
        end
        default: st_d = IDLE;
      endcase
    end

    assign oBTN_PULSE[b] = pulse_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_btn_conditioner : directed vectors for btn_conditioner (cDB=2)    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_btn_conditioner;

  localparam int unsigned TB_DB  = 2;
  localparam int unsigned TB_REP = 8;
`ifdef BTN_COND_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] btn;
  logic [3:0] sw;
  logic [1:0] lvl;
  logic [1:0] pulse;
  logic [3:0] swo;

  int n_tests = 0;
  int n_fail  = 0;

  btn_conditioner #(.cDB(TB_DB), .cREP(TB_REP)) dut (
    .iCLK_50    (clk),
    .iRST_N     (rst_n),
    .iBTN       (btn),
    .iSW        (sw),
    .oBTN_LVL   (lvl),
    .oBTN_PULSE (pulse),
    .oSW        (swo)
  );

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       rst_n;
    logic [1:0] btn;
    logic [3:0] sw;
    logic [1:0] e_lvl;
    logic [1:0] e_pulse;
    logic [3:0] e_sw;
    string      name;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic [1:0] b, input logic [3:0] s,
                              input logic [1:0] el, input logic [1:0] ep,
                              input logic [3:0] es, input string nm);
    vec_t v;
    v.rst_n = r; v.btn = b; v.sw = s;
    v.e_lvl = el; v.e_pulse = ep; v.e_sw = es; v.name = nm;
    vq.push_back(v);
  endfunction

  // Press strobe expected k cycles after a clean raw rising edge.
  function automatic logic exp_pulse(input int k);
    return (k == 4) || (REP_ON && k > 4 && ((k - 4) % TB_REP) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] el, input logic [1:0] ep,
                       input logic [3:0] es);
    n_tests++;
    if (lvl !== el || pulse !== ep || swo !== es) begin
      n_fail++;
      $display("FAIL %s @%0t: got lvl=%b pulse=%b sw=%h, want lvl=%b pulse=%b sw=%h",
               nm, $time, lvl, pulse, swo, el, ep, es);
    end
  endtask

  initial begin
    logic [3:0] bounce [8];
    rst_n = 1'b0;
    btn   = 2'b11;
    sw    = 4'hF;

    // Reset held with everything asserted, then released.
    for (int k = 1; k <= 3; k++) add(1'b0, 2'b11, 4'hF, 2'b00, 2'b00, 4'h0, "rst_hold");
    for (int k = 1; k <= 5; k++)
      add(1'b1, 2'b11, 4'hF, (k >= 4) ? 2'b11 : 2'b00, (k == 4) ? 2'b11 : 2'b00,
          (k >= 4) ? 4'hF : 4'h0, "rst_release");
    for (int k = 1; k <= 5; k++)
      add(1'b1, 2'b00, 4'h0, (k >= 4) ? 2'b00 : 2'b11, 2'b00,
          (k >= 4) ? 4'h0 : 4'hF, "release_all");
    // Clean press of button 0 held 20 cycles, then release.
    for (int k = 1; k <= 20; k++)
      add(1'b1, 2'b01, 4'h0, (k >= 4) ? 2'b01 : 2'b00, {1'b0, exp_pulse(k)}, 4'h0, "press0");
    for (int k = 1; k <= 6; k++)
      add(1'b1, 2'b00, 4'h0, (k >= 4) ? 2'b00 : 2'b01, 2'b00, 4'h0, "release0");
    // Single-cycle glitch on button 1.
    add(1'b1, 2'b10, 4'h0, 2'b00, 2'b00, 4'h0, "glitch1");
    for (int k = 2; k <= 7; k++) add(1'b1, 2'b00, 4'h0, 2'b00, 2'b00, 4'h0, "glitch1");
    // Switch 2 bounces 1/0/1 then holds; one rise 4 cycles after the last toggle.
    bounce = '{4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
    for (int k = 0; k < 8; k++)
      add(1'b1, 2'b00, bounce[k], 2'b00, 2'b00, (k >= 5) ? 4'h4 : 4'h0, "sw_bounce");
    // Simultaneous press of both buttons.
    for (int k = 1; k <= 5; k++)
      add(1'b1, 2'b11, 4'h4, (k >= 4) ? 2'b11 : 2'b00, (k == 4) ? 2'b11 : 2'b00, 4'h4,
          "both_press");
    for (int k = 1; k <= 5; k++)
      add(1'b1, 2'b00, 4'h4, (k >= 4) ? 2'b00 : 2'b11, 2'b00, 4'h4, "both_release");
    for (int k = 1; k <= 5; k++)
      add(1'b1, 2'b00, 4'h0, 2'b00, 2'b00, (k >= 4) ? 4'h0 : 4'h4, "sw_clear");

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      btn   = vq[i].btn;
      sw    = vq[i].sw;
      tick();
      check(vq[i].name, vq[i].e_lvl, vq[i].e_pulse, vq[i].e_sw);
    end

    // Reset pulse while button 0 is part-way through its debounce count.
    btn = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("midcnt_pre", 2'b00, 2'b00, 4'h0);
    end
    rst_n = 1'b0;
    #1;
    check("midcnt_in_rst", 2'b00, 2'b00, 4'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("midcnt_post", (k >= 4) ? 2'b01 : 2'b00, (k == 4) ? 2'b01 : 2'b00, 4'h0);
    end

    // Asynchronous reset with the level high, released while still held.
    rst_n = 1'b0;
    #1;
    check("async_rst", 2'b00, 2'b00, 4'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("held_reset", (k >= 4) ? 2'b01 : 2'b00, (k == 4) ? 2'b01 : 2'b00, 4'h0);
    end
    btn = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("held_release", (k >= 4) ? 2'b00 : 2'b01, 2'b00, 4'h0);
    end

    // Long hold: repeat strobes only when auto-repeat is built in.
    btn = 2'b01;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check("hold30", (k >= 4) ? 2'b01 : 2'b00, {1'b0, exp_pulse(k)}, 4'h0);
    end
    btn = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("release30", (k >= 4) ? 2'b00 : 2'b01, 2'b00, 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
